// File: rtl/bus_ctrl_pkg.sv
// Shared constants and types for the CPU-side bus controller and its serial transmitter.
package bus_ctrl_pkg;

  localparam logic [15:0] OFF_TXDATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0001;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  localparam logic [15:0] RAM_LIMIT   = 16'h8000;
  localparam logic [7:0]  UNMAPPED_RD = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/bus_ctrl_uart_tx.sv
// 8N1 serial transmitter; pops one byte from the FIFO per frame via a valid/ready handshake.
//
// state | meaning
// IDLE  | line high, ready to pop the next byte
// START | start bit (low) for BAUD_DIV cycles
// DATA  | 8 data bits, LSB first, BAUD_DIV cycles each
// STOP  | stop bit (high) for BAUD_DIV cycles
module bus_ctrl_uart_tx
  import bus_ctrl_pkg::*;
#(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pop_valid,
  input  logic [7:0] pop_data,
  output logic       pop_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

  uart_state_t state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  bit_idx, bit_d;
  logic [7:0]  shift, shift_d;
  logic        tx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shift   <= shift_d;
      tx      <= tx_d;
    end
  end

  // tx is registered from the next-state decision so each level lands on the transition edge
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_d     = bit_idx;
    shift_d   = shift;
    tx_d      = tx;
    pop_ready = 1'b0;
    case (state)
      IDLE: begin
        pop_ready = 1'b1;
        tx_d      = 1'b1;
        if (pop_valid) begin
          state_d = START;
          shift_d = pop_data;
          cnt_d   = BAUD_RELOAD;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cnt == '0) begin
          state_d = DATA;
          cnt_d   = BAUD_RELOAD;
          bit_d   = 3'd0;
          tx_d    = shift[0];
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_d = BAUD_RELOAD;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_idx + 3'd1;
            shift_d = {1'b0, shift[7:1]};
            tx_d    = shift[1];
          end
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cnt == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_busy = (state != IDLE);

endmodule

// File: rtl/bus_ctrl.sv
// CPU bus controller: mirrored RAM window, I/O page with STATUS and a TX FIFO feeding the UART.
module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int          RAM_AW     = 11,
  parameter int          FIFO_DEPTH = 8,
  parameter int          BAUD_DIV   = 104,
  parameter logic [15:0] IO_BASE    = 16'hF000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RW,
  input  logic [15:0] AD,
  input  logic [7:0]  D_out,
  output logic [7:0]  D_in,
  output logic        tx,
  output logic        tx_busy
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [7:0] ram      [2**RAM_AW];
  logic [7:0] fifo_mem [FIFO_DEPTH];

  logic [PW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_empty, overflow;
  logic        sel_ram, sel_txdata, sel_status, wr_en;
  logic        push_req, push_ok, pop, uart_ready, ovf_set, ovf_clr;
  logic [7:0]  status, rd_data;

  assign sel_ram    = (AD < RAM_LIMIT);
  assign sel_txdata = (AD == IO_BASE + OFF_TXDATA);
  assign sel_status = (AD == IO_BASE + OFF_STATUS);
  assign wr_en      = (RW == 1'b0);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign pop      = !fifo_empty && uart_ready;
  assign push_req = wr_en && sel_txdata;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok  = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && fifo_full && !pop;
  assign ovf_clr  = wr_en && sel_status && D_out[ST_OVF];

  always_comb begin
    status           = 8'h00;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = tx_busy;
    status[ST_OVF]   = overflow;
  end

  always_comb begin
    rd_data = UNMAPPED_RD;
    if (sel_ram)
      rd_data = ram[AD[RAM_AW-1:0]];
    else if (sel_txdata)
      rd_data = 8'h00;
    else if (sel_status)
      rd_data = status;
  end

  always_ff @(posedge clk) begin
    if (wr_en && sel_ram)
      ram[AD[RAM_AW-1:0]] <= D_out;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr[PW-1:0]] <= D_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D_in     <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (RW == 1'b1)
        D_in <= rd_data;
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (ovf_set)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  bus_ctrl_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk      (clk),
    .rst      (rst),
    .pop_valid(!fifo_empty),
    .pop_data (fifo_mem[rd_ptr[PW-1:0]]),
    .pop_ready(uart_ready),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

endmodule
